// File: rtl/alu_iter_pkg.sv
// Shared ALU definitions: operation encodings, FSM states and the
// operation classification helpers used by the decoder.
package alu_iter_pkg;

  localparam int ALU_WIDTH_DEFAULT     = 32;
  localparam int ALU_DIGIT_DEFAULT     = 8;
  localparam int ALU_SHIFT_MAX_DEFAULT = 8;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    EQ  = 4'd2,
    NE  = 4'd3,
    LT  = 4'd4,
    GE  = 4'd5,
    LTU = 4'd6,
    GEU = 4'd7,
    SLL = 4'd8,
    SRL = 4'd9,
    SRA = 4'd10
  } aluOp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARITH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } aluState_t;

  // True for the three shift operations, which use the shift stage.
  function automatic logic is_shift(aluOp_t op);
    return op inside {SLL, SRL, SRA};
  endfunction

  // True for the six compares, which produce a single result bit.
  function automatic logic is_cmp(aluOp_t op);
    return op inside {EQ, NE, LT, GE, LTU, GEU};
  endfunction

  // Unused encodings are folded onto ADD so the block can never stall on them.
  function automatic logic is_valid_op(aluOp_t op);
    return op inside {ADD, SUB, EQ, NE, LT, GE, LTU, GEU, SLL, SRL, SRA};
  endfunction

endpackage

// File: rtl/alu_iter_if.sv
// Request/response bundle between operand fetch, the iterative ALU
// and writeback. The master side issues requests and drains results.
interface alu_iter_if #(
  parameter int WIDTH = 32
);
  import alu_iter_pkg::*;

  logic             in_valid;
  logic             in_ready;
  aluOp_t           op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;

  modport master (
    output in_valid, op, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, cout
  );

  modport slave (
    input  in_valid, op, src_a, src_b, out_ready,
    output in_ready, out_valid, result, cout
  );

endinterface

// File: rtl/alu_iter_slice.sv
// One DIGIT-bit adder slice. The FSM feeds it one operand digit per
// cycle, LSB first, and keeps the carry in a register between calls.
module alu_iter_slice #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_sum,
  output logic             o_cout,
  output logic             o_zero
);

  logic [DIGIT:0] w_total;

  assign w_total = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT{1'b0}}, i_cin};
  assign o_sum   = w_total[DIGIT-1:0];
  assign o_cout  = w_total[DIGIT];
  assign o_zero  = (w_total[DIGIT-1:0] == '0);

endmodule

// File: rtl/alu_iter.sv
// Iterative integer ALU: add/sub and compares run one adder digit per
// cycle, shifts run a bounded distance per cycle. Results are held in
// DONE until the consumer takes them; a new request may be accepted in
// the same cycle the old result is consumed.
module alu_iter
  import alu_iter_pkg::*;
#(
  parameter int WIDTH     = ALU_WIDTH_DEFAULT,
  parameter int DIGIT     = ALU_DIGIT_DEFAULT,
  parameter int SHIFT_MAX = ALU_SHIFT_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  alu_iter_if.slave  bus
);

  localparam int N     = WIDTH / DIGIT;
  localparam int SLW   = (N > 1) ? $clog2(N) : 1;
  localparam int SHAMW = $clog2(WIDTH);
  localparam int STEPW = $clog2(SHIFT_MAX) + 1;

  // Parameter sanity checks, caught while elaborating.
  if ((WIDTH % DIGIT) != 0) begin : g_badDigit
    $error("alu_iter: WIDTH must be a multiple of DIGIT");
  end
  if ((SHIFT_MAX < 1) || ((SHIFT_MAX & (SHIFT_MAX - 1)) != 0) || (SHIFT_MAX > WIDTH)) begin : g_badShiftMax
    $error("alu_iter: SHIFT_MAX must be a power of two no larger than WIDTH");
  end

  aluState_t        r_state;
  aluOp_t           r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_zero;
  logic             r_fill;
  logic [SLW-1:0]   r_slice;
  logic [SHAMW-1:0] r_remain;
  logic             r_outValid;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;

  logic             w_accept;
  aluOp_t           w_opIn;
  logic [DIGIT-1:0] w_aDigit;
  logic [DIGIT-1:0] w_bRaw;
  logic [DIGIT-1:0] w_bDigit;
  logic [DIGIT-1:0] w_sliceSum;
  logic             w_sliceCout;
  logic             w_sliceZero;
  logic [WIDTH-1:0] w_sumExt;
  logic [WIDTH-1:0] w_sumNext;
  logic             w_zeroFinal;
  logic             w_lt;
  logic             w_cmpBit;
  logic [WIDTH-1:0] w_arithResult;
  logic             w_arithCout;
  logic [STEPW-1:0] w_step;
  logic [SHAMW-1:0] w_remainNext;
  logic [WIDTH-1:0] w_fillMask;
  logic [WIDTH-1:0] w_shifted;

  // Handshake: ready depends only on the state register and out_ready.
  assign bus.in_ready  = ~rst & ((r_state == IDLE) | ((r_state == DONE) & bus.out_ready));
  assign w_accept      = bus.in_valid & bus.in_ready;
  assign w_opIn        = is_valid_op(bus.op) ? bus.op : ADD;

  assign bus.out_valid = r_outValid;
  assign bus.result    = r_result;
  assign bus.cout      = r_cout;

  // Adder slice operands: low digit of the shifting operand registers.
  assign w_aDigit = r_a[DIGIT-1:0];
  assign w_bRaw   = r_b[DIGIT-1:0];
  assign w_bDigit = (r_op == ADD) ? w_bRaw : ~w_bRaw;

  alu_iter_slice #(
    .DIGIT (DIGIT)
  ) u_slice (
    .i_a    (w_aDigit),
    .i_b    (w_bDigit),
    .i_cin  (r_carry),
    .o_sum  (w_sliceSum),
    .o_cout (w_sliceCout),
    .o_zero (w_sliceZero)
  );

  // The new digit enters at the top so the sum is complete after N slices.
  assign w_sumExt    = WIDTH'(w_sliceSum);
  assign w_sumNext   = (r_sum >> DIGIT) | (w_sumExt << (WIDTH - DIGIT));
  assign w_zeroFinal = r_zero & w_sliceZero;

  // Signed less-than from the top digit: differing signs decide directly.
  assign w_lt = (w_aDigit[DIGIT-1] != w_bRaw[DIGIT-1]) ? w_aDigit[DIGIT-1] : w_sliceSum[DIGIT-1];

  // Compare outcome, meaningful on the last slice only.
  always_comb begin
    w_cmpBit = 1'b0;
    case (r_op)
      EQ:      w_cmpBit = w_zeroFinal;
      NE:      w_cmpBit = ~w_zeroFinal;
      LT:      w_cmpBit = w_lt;
      GE:      w_cmpBit = ~w_lt;
      LTU:     w_cmpBit = ~w_sliceCout;
      GEU:     w_cmpBit = w_sliceCout;
      default: w_cmpBit = 1'b0;
    endcase
  end

  assign w_arithResult = is_cmp(r_op) ? {{(WIDTH-1){1'b0}}, w_cmpBit} : w_sumNext;
  assign w_arithCout   = is_cmp(r_op) ? 1'b0 : w_sliceCout;

  // Per-cycle shift distance, clamped to what the shift stage can do.
  always_comb begin
    w_step = '0;
    if (int'(r_remain) > SHIFT_MAX) begin
      w_step = STEPW'(SHIFT_MAX);
    end else begin
      w_step = STEPW'(r_remain);
    end
  end

  assign w_remainNext = r_remain - SHAMW'(w_step);
  assign w_fillMask   = ~({WIDTH{1'b1}} >> w_step);

  // Bounded shift stage; SRA fills from the captured sign bit.
  always_comb begin
    w_shifted = r_a;
    case (r_op)
      SLL:     w_shifted = r_a << w_step;
      SRL:     w_shifted = r_a >> w_step;
      SRA:     w_shifted = (r_a >> w_step) | (r_fill ? w_fillMask : '0);
      default: w_shifted = r_a;
    endcase
  end

  // Control FSM and datapath registers; an accept overrides the case arm.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_op       <= ADD;
      r_a        <= '0;
      r_b        <= '0;
      r_sum      <= '0;
      r_carry    <= 1'b0;
      r_zero     <= 1'b0;
      r_fill     <= 1'b0;
      r_slice    <= '0;
      r_remain   <= '0;
      r_outValid <= 1'b0;
      r_result   <= '0;
      r_cout     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
        end
        ARITH: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_sum   <= w_sumNext;
          r_carry <= w_sliceCout;
          r_zero  <= w_zeroFinal;
          if (r_slice == SLW'(N - 1)) begin
            r_state    <= DONE;
            r_outValid <= 1'b1;
            r_result   <= w_arithResult;
            r_cout     <= w_arithCout;
          end else begin
            r_slice <= r_slice + 1'b1;
          end
        end
        SHIFT: begin
          r_a      <= w_shifted;
          r_remain <= w_remainNext;
          if (w_remainNext == '0) begin
            r_state    <= DONE;
            r_outValid <= 1'b1;
            r_result   <= w_shifted;
            r_cout     <= 1'b0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state    <= IDLE;
            r_outValid <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_outValid <= 1'b0;
        end
      endcase

      if (w_accept) begin
        r_op       <= w_opIn;
        r_a        <= bus.src_a;
        r_b        <= bus.src_b;
        r_sum      <= '0;
        r_carry    <= (w_opIn != ADD);
        r_zero     <= 1'b1;
        r_slice    <= '0;
        r_remain   <= bus.src_b[SHAMW-1:0];
        r_fill     <= (w_opIn == SRA) & bus.src_a[WIDTH-1];
        r_outValid <= 1'b0;
        r_state    <= is_shift(w_opIn) ? SHIFT : ARITH;
      end
    end
  end

endmodule
